// File: rtl/prio_hold_arbiter.sv
// rtl/prio_hold_arbiter.sv - priority arbiter with round-robin tie-break that holds each grant until the granted port's eop
// Optional aging is enabled by defining PRIO_AGING_EN.
module prio_hold_arbiter #(
    parameter int DATA_W    = 256,
    parameter int NUM_PORTS = 16,
    parameter int PRIO_W    = 3,
    parameter int PRIO_LSB  = 4,
    parameter int AGE_W     = 4,
    localparam int SEL_W    = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W*NUM_PORTS-1:0]   arb_data_in,
    input  logic [NUM_PORTS-1:0]          ready,
    input  logic [NUM_PORTS-1:0]          eop,
    output logic [NUM_PORTS*PRIO_W-1:0]   priority_out,
    output logic                          grant_valid,
    output logic [SEL_W-1:0]              grant_sel,
    output logic [NUM_PORTS-1:0]          grant_onehot,
    output logic [PRIO_W-1:0]             grant_prio
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                        state, state_nxt;
    logic [SEL_W-1:0]              rr_ptr, rr_ptr_nxt;
    logic [NUM_PORTS*PRIO_W-1:0]   priority_nxt;
    logic                          valid_nxt;
    logic [SEL_W-1:0]              sel_nxt;
    logic [NUM_PORTS-1:0]          onehot_nxt;
    logic [PRIO_W-1:0]             prio_nxt;

    logic [PRIO_W-1:0]             raw_prio [NUM_PORTS];
    logic [PRIO_W-1:0]             eff_prio [NUM_PORTS];
    logic [SEL_W-1:0]              win_idx;
    logic [PRIO_W-1:0]             win_prio;
    logic                          win_found;
    logic                          arbitrate;
    logic                          unused_bits;

    assign arbitrate   = (state == IDLE) && (|ready);
    assign unused_bits = ^{arb_data_in, AGE_W[0]};

    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_field
        assign raw_prio[j] = arb_data_in[j*DATA_W + PRIO_LSB +: PRIO_W];
    end

`ifdef PRIO_AGING_EN
    logic [AGE_W-1:0] age [NUM_PORTS];

    // A starved port is promoted to top priority once its counter saturates.
    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_age
        assign eff_prio[j] = (&age[j]) ? {PRIO_W{1'b1}} : raw_prio[j];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                age[j] <= '0;
            end else if (arbitrate) begin
                if (!ready[j] || (win_idx == SEL_W'(j)))
                    age[j] <= '0;
                else if (!(&age[j]))
                    age[j] <= age[j] + 1'b1;
            end
        end
    end
`else
    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_eff
        assign eff_prio[j] = raw_prio[j];
    end
`endif

    // Scan upward from rr_ptr; only a strictly higher priority displaces the first candidate.
    always_comb begin
        int idx;
        idx       = 0;
        win_idx   = '0;
        win_prio  = '0;
        win_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_PORTS)
                idx = idx - NUM_PORTS;
            if (ready[idx] && (!win_found || (eff_prio[idx] > win_prio))) begin
                win_found = 1'b1;
                win_idx   = SEL_W'(idx);
                win_prio  = eff_prio[idx];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        priority_nxt = priority_out;
        valid_nxt    = grant_valid;
        sel_nxt      = grant_sel;
        onehot_nxt   = grant_onehot;
        prio_nxt     = grant_prio;
        case (state)
            IDLE: begin
                if (|ready) begin
                    for (int j = 0; j < NUM_PORTS; j++)
                        priority_nxt[j*PRIO_W +: PRIO_W] = ready[j] ? raw_prio[j] : '0;
                    valid_nxt  = 1'b1;
                    sel_nxt    = win_idx;
                    onehot_nxt = NUM_PORTS'(1) << win_idx;
                    prio_nxt   = raw_prio[win_idx];
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (eop[grant_sel]) begin
                    priority_nxt = '0;
                    valid_nxt    = 1'b0;
                    sel_nxt      = '0;
                    onehot_nxt   = '0;
                    prio_nxt     = '0;
                    rr_ptr_nxt   = (int'(grant_sel) == NUM_PORTS - 1) ? '0 : grant_sel + 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            priority_out <= '0;
            grant_valid  <= 1'b0;
            grant_sel    <= '0;
            grant_onehot <= '0;
            grant_prio   <= '0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_ptr_nxt;
            priority_out <= priority_nxt;
            grant_valid  <= valid_nxt;
            grant_sel    <= sel_nxt;
            grant_onehot <= onehot_nxt;
            grant_prio   <= prio_nxt;
        end
    end

endmodule

// File: tb/tb_prio_hold_arbiter.sv
// tb/tb_prio_hold_arbiter.sv - directed self-checking bench for prio_hold_arbiter
module tb_prio_hold_arbiter;

    localparam int DATA_W    = 256;
    localparam int NUM_PORTS = 16;
    localparam int PRIO_W    = 3;
    localparam int PRIO_LSB  = 4;
    localparam int SEL_W     = 4;

    logic                        clk;
    logic                        rst_n;
    logic [DATA_W*NUM_PORTS-1:0] arb_data_in;
    logic [NUM_PORTS-1:0]        ready;
    logic [NUM_PORTS-1:0]        eop;
    logic [NUM_PORTS*PRIO_W-1:0] priority_out;
    logic                        grant_valid;
    logic [SEL_W-1:0]            grant_sel;
    logic [NUM_PORTS-1:0]        grant_onehot;
    logic [PRIO_W-1:0]           grant_prio;

    int total = 0;
    int bad   = 0;

    prio_hold_arbiter #(
        .DATA_W    (DATA_W),
        .NUM_PORTS (NUM_PORTS),
        .PRIO_W    (PRIO_W),
        .PRIO_LSB  (PRIO_LSB),
        .AGE_W     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arb_data_in  (arb_data_in),
        .ready        (ready),
        .eop          (eop),
        .priority_out (priority_out),
        .grant_valid  (grant_valid),
        .grant_sel    (grant_sel),
        .grant_onehot (grant_onehot),
        .grant_prio   (grant_prio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_prio(input int port, input int p);
        arb_data_in[port*DATA_W + PRIO_LSB +: PRIO_W] = p[PRIO_W-1:0];
    endtask

    initial begin
        rst_n       = 1'b0;
        ready       = 16'hFFFF;
        eop         = '0;
        arb_data_in = '0;
        #12;
        chk("rst_valid",  64'(grant_valid),  64'h0);
        chk("rst_sel",    64'(grant_sel),    64'h0);
        chk("rst_onehot", 64'(grant_onehot), 64'h0);
        chk("rst_prio",   64'(grant_prio),   64'h0);
        chk("rst_pout",   64'(priority_out), 64'h0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t1_valid", 64'(grant_valid), 64'h1);
        chk("t1_sel",   64'(grant_sel),   64'h0);
        ready = '0;
        eop   = 16'h0001;
        tick();
        chk("t1_release", 64'(grant_valid), 64'h0);
        eop = '0;

        // rr_ptr is now 1; port 4 outranks port 2 despite being scanned later
        set_prio(2, 3);
        set_prio(4, 6);
        ready = 16'h0014;
        tick();
        chk("t2_valid",  64'(grant_valid),  64'h1);
        chk("t2_sel",    64'(grant_sel),    64'h4);
        chk("t2_prio",   64'(grant_prio),   64'h6);
        chk("t2_onehot", 64'(grant_onehot), 64'h0010);
        chk("t2_pout",   64'(priority_out), 64'h60C0);
        ready = 16'hFFFF;
        eop   = 16'h0004;
        tick();
        chk("t2_hold_valid", 64'(grant_valid), 64'h1);
        chk("t2_hold_sel",   64'(grant_sel),   64'h4);
        chk("t2_hold_pout",  64'(priority_out), 64'h60C0);
        eop   = 16'h0010;
        ready = 16'h0014;
        tick();
        chk("t4_gap_valid",  64'(grant_valid),  64'h0);
        chk("t4_gap_onehot", 64'(grant_onehot), 64'h0);
        chk("t4_gap_pout",   64'(priority_out), 64'h0);
        eop = '0;
        tick();
        chk("t4_regrant_valid", 64'(grant_valid), 64'h1);
        chk("t4_regrant_sel",   64'(grant_sel),   64'h4);

        // asynchronous reset in the middle of a held grant
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_valid",  64'(grant_valid),  64'h0);
        chk("t5_async_onehot", 64'(grant_onehot), 64'h0);
        chk("t5_async_sel",    64'(grant_sel),    64'h0);
        ready = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t5_idle_valid", 64'(grant_valid), 64'h0);

        // equal priorities: rr_ptr=0 picks port 0, then port 8 once rr_ptr=1
        arb_data_in = '0;
        set_prio(0, 5);
        set_prio(8, 5);
        ready = 16'h0101;
        tick();
        chk("t3_sel0",    64'(grant_sel),    64'h0);
        chk("t3_onehot0", 64'(grant_onehot), 64'h0001);
        eop = 16'h0001;
        tick();
        chk("t3_gap_valid", 64'(grant_valid), 64'h0);
        eop = '0;
        tick();
        chk("t3_sel8",  64'(grant_sel),  64'h8);
        chk("t3_prio8", 64'(grant_prio), 64'h5);
        eop   = 16'h0100;
        ready = '0;
        tick();
        chk("t3_end_valid", 64'(grant_valid), 64'h0);

        // lone priority-0 port wins; its eop during the arbitrating cycle is ignored
        arb_data_in = '0;
        ready = 16'h8000;
        eop   = 16'h8000;
        tick();
        chk("p0_valid",  64'(grant_valid),  64'h1);
        chk("p0_sel",    64'(grant_sel),    64'hF);
        chk("p0_prio",   64'(grant_prio),   64'h0);
        chk("p0_onehot", 64'(grant_onehot), 64'h8000);
        eop = '0;
        tick();
        chk("eop_ignored_valid", 64'(grant_valid), 64'h1);
        eop   = 16'h8000;
        ready = '0;
        tick();
        chk("p15_release", 64'(grant_valid), 64'h0);
        eop = '0;

        // rr_ptr wrapped from 15 to 0, so port 0 wins the tie against port 15
        ready = 16'h8001;
        tick();
        chk("wrap_sel",  64'(grant_sel),    64'h0);
        chk("wrap_pout", 64'(priority_out), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
